// File: rtl/cube_move_sequencer.sv
// rtl/cube_move_sequencer.sv - replays stored scramble/solution move sequences to the actuator
// one move per valid/ack handshake, tracking whether the cube is currently scrambled.
module cube_move_sequencer #(
   parameter int NUM_SEQ = 4,
   parameter int MAX_LEN = 32,
   parameter int MOVE_W = 4,
   parameter logic [MOVE_W-1:0] IDLE_CODE = '1,
   parameter int GAP_CYCLES = 0,
   localparam int SEL_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1,
   localparam int LEN_W = $clog2(MAX_LEN + 1),
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_scramble,
   input  logic              start_solve,
   input  logic [SEL_W-1:0]  seq_sel,
   input  logic              abort,
   output logic [MOVE_W-1:0] move_code,
   output logic              move_valid,
   input  logic              move_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              scrambled,
   output logic [SEL_W-1:0]  cur_sel,
   input  logic              cfg_we,
   input  logic              cfg_kind,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [IDX_W-1:0]  cfg_addr,
   input  logic [MOVE_W-1:0] cfg_data,
   input  logic              cfg_len_we,
   input  logic [LEN_W-1:0]  cfg_len
);

   localparam int RAM_DEPTH = 2 * NUM_SEQ * MAX_LEN;
   localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int LIDX_W = $clog2(2 * NUM_SEQ);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_FINISH} state_t;

   state_t              state, state_nxt;
   logic                kind, kind_nxt;
   logic [SEL_W-1:0]    sel_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [GAP_W-1:0]    gap_cnt, gap_nxt;
   logic                scr_nxt, err_nxt;
   logic [MOVE_W-1:0]   rd_data;
   logic [LEN_W-1:0]    cur_len;
   logic [LEN_W-1:0]    lens [2*NUM_SEQ];
   logic [MOVE_W-1:0]   ram [RAM_DEPTH];
   logic                cfg_ok;

   function automatic logic [LIDX_W-1:0] len_idx(input logic k, input logic [SEL_W-1:0] s);
      return LIDX_W'((k ? NUM_SEQ : 0) + int'(s));
   endfunction

   function automatic logic [ADDR_W-1:0] ram_addr(input logic k, input logic [SEL_W-1:0] s,
                                                  input logic [IDX_W-1:0] i);
      return ADDR_W'(((k ? NUM_SEQ : 0) + int'(s)) * MAX_LEN + int'(i));
   endfunction

   assign cur_len = lens[len_idx(kind, cur_sel)];
   // Tables are frozen while a run is in progress so the replay stays consistent.
   assign cfg_ok  = rst_n && (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         kind      <= 1'b0;
         cur_sel   <= '0;
         idx       <= '0;
         gap_cnt   <= '0;
         scrambled <= 1'b0;
         err       <= 1'b0;
         for (int i = 0; i < 2*NUM_SEQ; i++) lens[i] <= '0;
      end else begin
         state     <= state_nxt;
         kind      <= kind_nxt;
         cur_sel   <= sel_nxt;
         idx       <= idx_nxt;
         gap_cnt   <= gap_nxt;
         scrambled <= scr_nxt;
         err       <= err_nxt;
         if (cfg_len_we && cfg_ok)
            lens[len_idx(cfg_kind, cfg_sel)] <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_we && cfg_ok)
         ram[ram_addr(cfg_kind, cfg_sel, cfg_addr)] <= cfg_data;
      if (state == S_FETCH)
         rd_data <= ram[ram_addr(kind, cur_sel, idx)];
   end

   always_comb begin
      state_nxt = state;
      kind_nxt  = kind;
      sel_nxt   = cur_sel;
      idx_nxt   = idx;
      gap_nxt   = gap_cnt;
      scr_nxt   = scrambled;
      err_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_scramble) begin
               kind_nxt = 1'b0;
               sel_nxt  = seq_sel;
               idx_nxt  = '0;
               if (lens[len_idx(1'b0, seq_sel)] == '0) begin
                  state_nxt = S_FINISH;
                  scr_nxt   = 1'b1;
               end else begin
                  state_nxt = S_FETCH;
               end
            end else if (start_solve) begin
               if (scrambled) begin
                  kind_nxt = 1'b1;
                  idx_nxt  = '0;
                  if (lens[len_idx(1'b1, cur_sel)] == '0) begin
                     state_nxt = S_FINISH;
                     scr_nxt   = 1'b0;
                  end else begin
                     state_nxt = S_FETCH;
                  end
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_FETCH: state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (move_ack) begin
               if (LEN_W'(idx) + LEN_W'(1) == cur_len) begin
                  state_nxt = S_FINISH;
                  scr_nxt   = ~kind;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  gap_nxt   = '0;
                  state_nxt = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
               end
            end
         end
         S_GAP: begin
            if (int'(gap_cnt) >= GAP_CYCLES - 1) state_nxt = S_FETCH;
            else gap_nxt = gap_cnt + GAP_W'(1);
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      // A half-played scramble still leaves the cube dirty; a half-played solve does too.
      if (abort && state != S_IDLE) begin
         state_nxt = S_IDLE;
         scr_nxt   = kind ? scrambled : 1'b1;
      end
   end

   always_comb begin
      busy       = (state != S_IDLE);
      move_valid = (state == S_ISSUE);
      move_code  = (state == S_ISSUE) ? rd_data : IDLE_CODE;
      done       = (state == S_FINISH);
   end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// tb/tb_cube_move_sequencer.sv - scoreboard bench for cube_move_sequencer with a table-level
// reference model; a monitor pops expected moves/done/err events as the DUT presents them.
module tb_cube_move_sequencer;
   localparam int NUM_SEQ = 4;
   localparam int MAX_LEN = 32;
   localparam int MOVE_W = 4;
   localparam int SEL_W = 2;
   localparam int LEN_W = 6;
   localparam int IDX_W = 5;
   localparam logic [3:0] IDLE_CODE = 4'b1111;
   localparam int EV_DONE = 1000;
   localparam int EV_ERR = 2000;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start_scramble = 1'b0, start_solve = 1'b0, abort = 1'b0, move_ack = 1'b0;
   logic [SEL_W-1:0] seq_sel = '0, cfg_sel = '0;
   logic cfg_we = 1'b0, cfg_kind = 1'b0, cfg_len_we = 1'b0;
   logic [IDX_W-1:0] cfg_addr = '0;
   logic [MOVE_W-1:0] cfg_data = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [MOVE_W-1:0] move_code;
   logic move_valid, busy, done, err, scrambled;
   logic [SEL_W-1:0] cur_sel;

   int errors = 0, checks = 0;
   int exp_q[$];
   int m_ram [2][NUM_SEQ][MAX_LEN];
   int m_len [2][NUM_SEQ];
   bit m_scr = 1'b0;
   int m_cur = 0;
   bit ack_auto = 1'b1, ack_rand = 1'b0;
   logic [8:0] cv, cd, cb, ce;

   always #5 clk = ~clk;

   cube_move_sequencer #(.NUM_SEQ(NUM_SEQ), .MAX_LEN(MAX_LEN), .MOVE_W(MOVE_W),
                         .IDLE_CODE(IDLE_CODE), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .start_scramble(start_scramble), .start_solve(start_solve),
      .seq_sel(seq_sel), .abort(abort), .move_code(move_code), .move_valid(move_valid),
      .move_ack(move_ack), .busy(busy), .done(done), .err(err), .scrambled(scrambled),
      .cur_sel(cur_sel), .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_sel(cfg_sel),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len));

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic sb_pop(input string name, input int got);
      int e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_%s: got %0d expected no event", name, got);
      end else begin
         e = exp_q.pop_front();
         if (e != got) begin
            errors++;
            $display("FAIL sb_%s: got %0d expected %0d", name, got, e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (move_valid && move_ack) sb_pop("move", int'(move_code));
         if (done) sb_pop("done", EV_DONE);
         if (err) sb_pop("err", EV_ERR);
      end
   end

   always begin
      @(posedge clk); #1;
      if (ack_auto) move_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic cfg_move(input int k, input int s, input int a, input int d, input bit upd);
      cfg_we = 1'b1; cfg_kind = k[0]; cfg_sel = SEL_W'(s); cfg_addr = IDX_W'(a); cfg_data = MOVE_W'(d);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (upd) m_ram[k][s][a] = d;
   endtask

   task automatic cfg_length(input int k, input int s, input int l, input bit upd);
      cfg_len_we = 1'b1; cfg_kind = k[0]; cfg_sel = SEL_W'(s); cfg_len = LEN_W'(l);
      @(posedge clk); #1;
      cfg_len_we = 1'b0;
      if (upd) m_len[k][s] = (l > MAX_LEN) ? MAX_LEN : l;
   endtask

   task automatic load_seq(input int k, input int s, input int l);
      for (int i = 0; i < l && i < MAX_LEN; i++) cfg_move(k, s, i, $urandom_range(0, 15), 1'b1);
      cfg_length(k, s, l, 1'b1);
   endtask

   task automatic start(input bit scr, input bit sol, input int sel);
      int k;
      if (scr) begin k = 0; m_cur = sel; end
      else if (sol && m_scr) k = 1;
      else k = -1;
      if (k < 0) begin
         if (sol) exp_q.push_back(EV_ERR);
      end else begin
         for (int i = 0; i < m_len[k][m_cur]; i++) exp_q.push_back(m_ram[k][m_cur][i]);
         exp_q.push_back(EV_DONE);
         m_scr = (k == 0);
      end
      seq_sel = SEL_W'(sel); start_scramble = scr; start_solve = sol;
      @(posedge clk); #1;
      start_scramble = 1'b0; start_solve = 1'b0;
   endtask

   task automatic capture(output logic [8:0] v, output logic [8:0] d, output logic [8:0] b,
                          output logic [8:0] e);
      v = '0; d = '0; b = '0; e = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         v[k] = move_valid; d[k] = done; b[k] = busy; e[k] = err;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_timeout"}, int'(n < 500), 1);
      check({name, "_scrambled"}, int'(scrambled), int'(m_scr));
      check({name, "_cur_sel"}, int'(cur_sel), m_cur);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s, sel, d;
      // reset with a start pending
      rst_n = 1'b0; start_scramble = 1'b1; seq_sel = 2'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", int'(move_valid), 0);
      check("rst_code", int'(move_code), int'(IDLE_CODE));
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_scrambled", int'(scrambled), 0);
      check("rst_cur_sel", int'(cur_sel), 0);
      @(posedge clk); #1;
      start_scramble = 1'b0; rst_n = 1'b1;

      // solve before any scramble is rejected
      start(1'b0, 1'b1, 0);
      capture(cv, cd, cb, ce);
      check("err_pulse", int'(ce), 9'h002);
      check("err_busy", int'(cb), 0);
      check("err_valid", int'(cv), 0);
      wait_idle("err");

      // basic scramble {0,1,13} on seq 2, ack tied high
      cfg_move(0, 2, 0, 0, 1'b1); cfg_move(0, 2, 1, 1, 1'b1); cfg_move(0, 2, 2, 13, 1'b1);
      cfg_length(0, 2, 3, 1'b1);
      load_seq(1, 2, 4);
      start(1'b1, 1'b0, 2);
      capture(cv, cd, cb, ce);
      check("basic_valid_pattern", int'(cv), 9'h054);
      check("basic_done_pattern", int'(cd), 9'h080);
      check("basic_busy_pattern", int'(cb), 9'h0FE);
      wait_idle("basic");

      // solve uses the latched selection, not seq_sel
      start(1'b0, 1'b1, 0);
      wait_idle("solve");

      // zero-length scramble then zero-length solve
      start(1'b1, 1'b0, 1);
      capture(cv, cd, cb, ce);
      check("zero_valid", int'(cv), 0);
      check("zero_done", int'(cd), 9'h002);
      check("zero_busy", int'(cb), 9'h002);
      wait_idle("zero_scr");
      start(1'b0, 1'b1, 3);
      wait_idle("zero_sol");

      // ack stall on the first move
      load_seq(0, 0, 3);
      ack_auto = 1'b0; move_ack = 1'b0;
      start(1'b1, 1'b0, 0);
      k = 0;
      while (!move_valid && k < 10) begin @(negedge clk); k++; end
      check("stall_reach_valid", int'(move_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_valid", int'(move_valid), 1);
         check("stall_code", int'(move_code), m_ram[0][0][0]);
      end
      @(posedge clk); #1;
      move_ack = 1'b1; ack_auto = 1'b1;
      wait_idle("stall");

      // table writes while busy are dropped
      d = (m_ram[0][0][0] + 1) % 16;
      start(1'b1, 1'b0, 0);
      cfg_move(0, 0, 0, d, 1'b0);
      cfg_length(0, 0, 1, 1'b0);
      wait_idle("busy_wr_run");
      start(1'b1, 1'b0, 0);
      wait_idle("busy_wr_replay");

      // abort a scramble while move 2 of 5 is presented
      load_seq(0, 1, 5);
      start(1'b1, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_remaining", exp_q.size(), 4);
      exp_q.delete();
      @(negedge clk);
      check("abort_valid", int'(move_valid), 0);
      check("abort_code", int'(move_code), int'(IDLE_CODE));
      check("abort_busy", int'(busy), 0);
      repeat (5) @(negedge clk);
      wait_idle("abort_scr");

      // abort a solve: cube stays dirty
      load_seq(1, 1, 4);
      start(1'b0, 1'b1, 0);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      m_scr = 1'b1;
      repeat (5) @(negedge clk);
      wait_idle("abort_sol");

      // over-long length clamps to MAX_LEN
      load_seq(0, 3, MAX_LEN + 5);
      check("clamp_model_len", m_len[0][3], MAX_LEN);
      start(1'b1, 1'b0, 3);
      wait_idle("clamp");

      // simultaneous starts: scramble wins
      start(1'b1, 1'b1, 1);
      wait_idle("both_starts");

      // randomized runs with random ack
      ack_rand = 1'b1;
      for (int it = 0; it < 25; it++) begin
         k = $urandom_range(0, 1);
         s = $urandom_range(0, 3);
         sel = $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0) load_seq(k, s, $urandom_range(0, 6));
         case ($urandom_range(0, 3))
            0, 1: start(1'b1, 1'b0, sel);
            2: start(1'b0, 1'b1, sel);
            default: start(1'b1, 1'b1, sel);
         endcase
         wait_idle("rand");
      end
      ack_rand = 1'b0;

      // reset in the middle of a run clears state and lengths
      load_seq(0, 0, 6);
      start(1'b1, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 2; i++) for (int j = 0; j < NUM_SEQ; j++) m_len[i][j] = 0;
      m_scr = 1'b0; m_cur = 0;
      @(negedge clk);
      check("midrst_busy", int'(busy), 0);
      check("midrst_valid", int'(move_valid), 0);
      check("midrst_scrambled", int'(scrambled), 0);
      @(posedge clk); #1;
      start(1'b1, 1'b0, 0);
      capture(cv, cd, cb, ce);
      check("midrst_len_zero_done", int'(cd), 9'h002);
      check("midrst_len_zero_valid", int'(cv), 0);
      wait_idle("midrst");

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cube_move_sequencer.md
# cube_move_sequencer

Parametrised move-sequence player for the cube solver. It stores NUM_SEQ scramble/solution sequence pairs in a runtime-writable table. It replays a selected sequence one move at a time to the actuator interface, which drives the FPGA-to-Arduino face decoder, with a valid/ack handshake per move. The selection is latched at start so that it cannot change mid-run, the block tracks whether the cube is currently scrambled, and a run can be aborted.

## Interface
Parameters:
- NUM_SEQ, 4, number of scramble/solution pairs; SEL_W = max(1, clog2(NUM_SEQ))
- MAX_LEN, 32, max moves per sequence; LEN_W = clog2(MAX_LEN+1), IDX_W = max(1, clog2(MAX_LEN))
- MOVE_W, 4, move-code width
- IDLE_CODE, 4'b1111, move_code driven when no move is pending
- GAP_CYCLES, 0, idle cycles inserted after each ack before the next fetch (0 allowed)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- start_scramble  in  1  pulse; play scramble[seq_sel]
- start_solve  in  1  pulse; play solution[latched sel]
- seq_sel  in  SEL_W  sequence index, sampled only on an accepted start_scramble
- abort  in  1  level/pulse; terminate the current run
- move_code  out  MOVE_W  current move; IDLE_CODE when move_valid=0
- move_valid  out  1  move_code is presented to the actuator
- move_ack  in  1  actuator accepted/finished move; meaningful only while move_valid=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse when start_solve is rejected
- scrambled  out  1  cube is in a scrambled state (replaces legacy retain)
- cur_sel  out  SEL_W  latched selection
- cfg_we  in  1  table write strobe
- cfg_kind  in  1  0 = scramble table, 1 = solution table
- cfg_sel  in  SEL_W  sequence index
- cfg_addr  in  IDX_W  move index
- cfg_data  in  MOVE_W  move code
- cfg_len_we  in  1  write length of (cfg_kind, cfg_sel) from cfg_len
- cfg_len  in  LEN_W  sequence length; values > MAX_LEN are stored as MAX_LEN

## Operation
- Storage: move RAM of 2·NUM_SEQ·MAX_LEN × MOVE_W with a synchronous read port, plus 2·NUM_SEQ length registers.
- cfg_we and cfg_len_we take effect only when busy=0; when busy=1 they are dropped silently.
- Reset values:
  - Outputs: move_valid=0, move_code=IDLE_CODE, busy=0, done=0, err=0, scrambled=0, cur_sel=0.
  - All lengths are 0. RAM contents are undefined (not reset).
- FSM states: IDLE, FETCH, ISSUE, GAP, FINISH.
- IDLE:
  - start_scramble has priority over start_solve if both are asserted in the same cycle.
  - start_scramble: latch cur_sel=seq_sel, kind=0, idx=0.
  - start_solve with scrambled=1: kind=1, idx=0; cur_sel is unchanged.
  - start_solve with scrambled=0: err pulse, stay in IDLE.
  - After an accepted start, go to FINISH if the selected length is 0, otherwise go to FETCH.
- FETCH: issue the RAM read at {kind, cur_sel, idx}, then go to ISSUE.
- ISSUE:
  - move_valid=1, with move_code held stable from RAM data until ack.
  - On move_ack=1, go to FINISH if idx == len-1. Otherwise increment idx and go to GAP, or to FETCH if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to FETCH.
- FINISH:
  - Pulse done.
  - scrambled ← 1 after a scramble; scrambled ← 0 after a solve.
  - Go to IDLE.
- Start pulses outside IDLE are ignored.
- abort in any non-IDLE state:
  - Next state is IDLE, with move_valid=0 and move_code=IDLE_CODE on the following edge. No done pulse.
  - Abort during a scramble sets scrambled=1 (the cube is considered dirty). Abort during a solve leaves scrambled=1.
- move_ack while move_valid=0 is ignored.
- A zero-length solve completes immediately (done pulse) and clears scrambled.

## Timing
- Accepted start sampled at edge t:
  - busy=1 from edge t+1 (FETCH during t+1..t+2).
  - move_valid=1 from edge t+2.
- move_ack sampled high at edge a (while move_valid=1):
  - move_valid=0 from edge a+1.
  - If a next move exists, move_valid rises again at edge a+GAP_CYCLES+2.
- Last ack at edge a:
  - done=1 for exactly the cycle starting at edge a+1; scrambled is updated at edge a+1.
  - busy=0 from edge a+2.
- Throughput with GAP_CYCLES=0 and move_ack tied high: one move per 2 cycles.
- Zero-length start at edge t: done pulse at edge t+1, busy=0 at edge t+2.
- rst_n=0 overrides everything, including a mid-run sequence, on the next edge. Length registers return to 0.
- err is asserted on edge t+1 after the rejected start.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start_scramble=1 → outputs at the stated reset values, no move_valid, busy=0.
- Basic scramble: load scramble[2] = {0,1,13} with len 3, seq_sel=2, move_ack tied 1, GAP_CYCLES=0 → move_code sequence 0,1,13, each valid 1 cycle, 2-cycle spacing; done at edge 7 after start; scrambled=1.
- Solve before scramble: start_solve after reset → err pulse, busy stays 0. After the scramble above, start_solve with seq_sel changed to 0 → plays solution[2], done pulse, scrambled=0.
- Ack stall: hold move_ack=0 for 10 cycles on move 1 → move_valid and move_code stable for all 10 cycles; idx advances only after ack.
- Abort and busy writes: abort mid-scramble at move 2 of 5 → move_valid=0 next edge, no done, scrambled=1. cfg_we while busy → table entry unchanged on readback replay.
- Boundaries: cfg_len=MAX_LEN+5 → plays exactly MAX_LEN moves. Length 0 → done without any move_valid. start_scramble and start_solve in the same cycle → scramble runs.
